// File: rtl/addsub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM state encoding and mode constants.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit for overflow detection.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder; the basic cell of the ripple stage.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/sub processing CHUNK bits per clock, LSB chunk first, with start/busy/done handshake.
// Define ADDSUB_SAT_EN to clamp the result to the signed limit on overflow.
module chunked_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             borrow,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("chunked_addsub: WIDTH must be >= 2");
  end
  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_addsub: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_slice, b_slice, sum;
  logic             cout, c_msb_in;

  // b_q already holds the (possibly inverted) second operand, so the ripple stage only ever adds.
  assign base    = 32'(cnt_q) * 32'(CHUNK);
  assign a_slice = a_q[base +: CHUNK];
  assign b_slice = b_q[base +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a       (a_slice),
    .b       (b_slice),
    .cin     (c_q),
    .sum     (sum),
    .cout    (cout),
    .c_msb_in(c_msb_in)
  );

  always_comb begin
    // NOTE: every _d signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    mode_d     = mode_q;
    result_d   = result_q;
    carry_d    = carry_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = b ^ {WIDTH{mode}};
          c_d     = mode;
          mode_d  = mode;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        result_d[base +: CHUNK] = sum;
        c_d = cout;
        if (cnt_q == LAST) begin
          state_d    = ST_DONE;
          carry_d    = cout;
          borrow_d   = (mode_q == MODE_SUB) & ~cout;
          overflow_d = c_msb_in ^ cout;
`ifdef ADDSUB_SAT_EN
          // A wrapped MSB of 1 means the true result was positive, and vice versa.
          if (c_msb_in ^ cout) begin
            result_d = sum[CHUNK-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                    : {1'b1, {(WIDTH-1){1'b0}}};
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, so every output reads 0 the cycle after rst.
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      mode_q     <= MODE_ADD;
      result_q   <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      mode_q     <= mode_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign carry    = carry_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;

endmodule
